// File: rtl/ula_op_sequencer.sv
// Valid/ready control stage that holds one ALU operation for EXEC_CYCLES settle cycles, then presents the registered result and flags.
// Optional macro ULA_ACC_CHAIN_EN adds a CHAIN input that feeds the previous RESULT back as operand A.
module ula_op_sequencer #(
  parameter int EXEC_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       IN_VALID,
  output logic       IN_READY,
  input  logic [1:0] OP,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       CIN,
`ifdef ULA_ACC_CHAIN_EN
  input  logic       CHAIN,
`endif
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic [7:0] RESULT,
  output logic       COUT,
  output logic       ZERO,
  output logic       NEG,
  output logic       OVF,
  output logic       BUSY
);

  localparam int unsigned EXEC_N = (EXEC_CYCLES < 1) ? 1 : EXEC_CYCLES;
  localparam int unsigned CNT_W  = (EXEC_N > 1) ? $clog2(EXEC_N) : 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_q;
  logic [7:0]       a_q;
  logic [7:0]       b_q;
  logic             cin_q;
  logic [7:0]       a_src;

  logic [8:0]       wide;
  logic [7:0]       alu_res;
  logic             alu_cout;
  logic             alu_ovf;

  // Reset must block acceptance even before the reset edge lands.
  assign IN_READY = !RST && !BUSY;

`ifdef ULA_ACC_CHAIN_EN
  assign a_src = CHAIN ? RESULT : A;
`else
  assign a_src = A;
`endif

  // Result computed from the latched operands only.
  always_comb begin
    wide     = 9'd0;
    alu_res  = 8'd0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    case (op_q)
      OP_ADD: begin
        wide     = {1'b0, a_q} + {1'b0, b_q} + 9'(cin_q);
        alu_res  = wide[7:0];
        alu_cout = wide[8];
        alu_ovf  = (a_q[7] == b_q[7]) && (wide[7] != a_q[7]);
      end
      OP_SUB: begin
        // Bit 8 of the 9-bit difference is the unsigned borrow.
        wide     = {1'b0, a_q} - {1'b0, b_q} - 9'(cin_q);
        alu_res  = wide[7:0];
        alu_cout = wide[8];
        alu_ovf  = (a_q[7] != b_q[7]) && (wide[7] != a_q[7]);
      end
      OP_AND:  alu_res = a_q & b_q;
      default: alu_res = a_q | b_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      cnt       <= '0;
      op_q      <= 2'd0;
      a_q       <= 8'd0;
      b_q       <= 8'd0;
      cin_q     <= 1'b0;
      RESULT    <= 8'd0;
      COUT      <= 1'b0;
      ZERO      <= 1'b0;
      NEG       <= 1'b0;
      OVF       <= 1'b0;
      OUT_VALID <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (IN_VALID) begin
            op_q  <= OP;
            a_q   <= a_src;
            b_q   <= B;
            cin_q <= CIN;
            cnt   <= CNT_W'(EXEC_N - 1);
            BUSY  <= 1'b1;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt == '0) begin
            RESULT    <= alu_res;
            COUT      <= alu_cout;
            ZERO      <= (alu_res == 8'd0);
            NEG       <= alu_res[7];
            OVF       <= alu_ovf;
            OUT_VALID <= 1'b1;
            state     <= S_DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            BUSY      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
